// File: rtl/siw_memory_bram_p.sv
// siw_memory_bram_p: dual-port BRAM wrapper with delayed write enables,
// hardware clear sweep and same-address write collision flag.
module siw_memory_bram_p #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10,
  parameter int DLY_MAX = 3,
  parameter int OUT_REG = 1,
  parameter logic [DATA_W-1:0] INIT_VAL = '0,
  localparam int CONF_W = $clog2(DLY_MAX + 1)
) (
  input  logic              siw_memory_bram_p_clk,
  input  logic              siw_memory_bram_p_reset,
  input  logic              siw_memory_bram_p_init,
  input  logic              siw_memory_bram_p_mem_sel,
  output logic              siw_memory_bram_p_busy,
  output logic              siw_memory_bram_p_collision,
  input  logic              siw_memory_bram_p_enable_a,
  input  logic              siw_memory_bram_p_enable_b,
  input  logic              siw_memory_bram_p_write_en_a,
  input  logic              siw_memory_bram_p_write_en_b,
  input  logic [ADDR_W-1:0] siw_memory_bram_p_address_a,
  input  logic [ADDR_W-1:0] siw_memory_bram_p_address_b,
  input  logic [DATA_W-1:0] siw_memory_bram_p_input_data_a,
  input  logic [DATA_W-1:0] siw_memory_bram_p_input_data_b,
  input  logic [CONF_W-1:0] siw_memory_bram_p_mem_conf_a,
  input  logic [CONF_W-1:0] siw_memory_bram_p_mem_conf_b,
  output logic [DATA_W-1:0] siw_memory_bram_p_output_data_a,
  output logic [DATA_W-1:0] siw_memory_bram_p_output_data_b
);

  typedef enum logic {IDLE, CLEAR} state_e;

  logic clk, rst, init;
  assign clk  = siw_memory_bram_p_clk;
  assign rst  = siw_memory_bram_p_reset;
  assign init = siw_memory_bram_p_init;

  state_e state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DLY_MAX-1:0] stg_a_q, stg_a_d;
  logic [DLY_MAX-1:0] stg_b_q, stg_b_d;
  logic coll_q, coll_d;

  logic [DLY_MAX:0] tap_a, tap_b;
  logic [CONF_W-1:0] sel_a, sel_b;
  logic wr_a, wr_b, wen_a, wen_b, clr;

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] rd_a_q, rd_b_q;
  logic mw_a, mw_b;
  logic [ADDR_W-1:0] mw_a_addr;
  logic [DATA_W-1:0] mw_a_data;

  assign clr = (state_q == CLEAR);

  // Tap 0 is the live request; tap k is the request k cycles old.
  always_comb begin
    tap_a = {stg_a_q, siw_memory_bram_p_write_en_a};
    tap_b = {stg_b_q, siw_memory_bram_p_write_en_b};
    sel_a = siw_memory_bram_p_mem_conf_a;
    sel_b = siw_memory_bram_p_mem_conf_b;
    if (int'(sel_a) > DLY_MAX) sel_a = CONF_W'(DLY_MAX);
    if (int'(sel_b) > DLY_MAX) sel_b = CONF_W'(DLY_MAX);
    wr_a = tap_a[sel_a];
    wr_b = tap_b[sel_b];
    stg_a_d = init ? '0 : tap_a[DLY_MAX-1:0];
    stg_b_d = init ? '0 : tap_b[DLY_MAX-1:0];
  end

  always_comb begin
    wen_a = wr_a & ~clr &
            (siw_memory_bram_p_enable_a | siw_memory_bram_p_mem_sel);
    wen_b = wr_b & ~clr & siw_memory_bram_p_enable_b;
    coll_d = wen_a & wen_b &
             (siw_memory_bram_p_address_a == siw_memory_bram_p_address_b);
    mw_a = clr | wen_a;
    mw_a_addr = clr ? cnt_q : siw_memory_bram_p_address_a;
    mw_a_data = clr ? INIT_VAL : siw_memory_bram_p_input_data_a;
    mw_b = wen_b & ~coll_d;
  end

  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (init) begin
          state_d = CLEAR;
          cnt_d = '0;
        end
      end
      CLEAR: begin
        if (init) begin
          cnt_d = '0;
        end else if (cnt_q == '1) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      stg_a_q <= '0;
      stg_b_q <= '0;
      coll_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      stg_a_q <= stg_a_d;
      stg_b_q <= stg_b_d;
      coll_q <= coll_d;
    end
  end

  // Array has no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (mw_a) mem[mw_a_addr] <= mw_a_data;
    if (mw_b) mem[siw_memory_bram_p_address_b] <= siw_memory_bram_p_input_data_b;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_a_q <= '0;
      rd_b_q <= '0;
    end else begin
      rd_a_q <= mem[siw_memory_bram_p_address_a];
      rd_b_q <= mem[siw_memory_bram_p_address_b];
    end
  end

  generate
    if (OUT_REG != 0) begin : g_oreg
      logic [DATA_W-1:0] out_a_q, out_b_q;
      always_ff @(posedge clk) begin
        if (rst) begin
          out_a_q <= '0;
          out_b_q <= '0;
        end else begin
          out_a_q <= rd_a_q;
          out_b_q <= rd_b_q;
        end
      end
      assign siw_memory_bram_p_output_data_a = out_a_q;
      assign siw_memory_bram_p_output_data_b = out_b_q;
    end else begin : g_direct
      assign siw_memory_bram_p_output_data_a = rd_a_q;
      assign siw_memory_bram_p_output_data_b = rd_b_q;
    end
  endgenerate

  assign siw_memory_bram_p_busy = clr;
  assign siw_memory_bram_p_collision = coll_q;

endmodule

// File: tb/tb_siw_memory_bram_p.sv
// tb_siw_memory_bram_p: randomized + directed stimulus, reference model
// feeding a scoreboard queue drained by an independent monitor.
module tb_siw_memory_bram_p;

  localparam int NMAX = 20000;
  localparam int DEPTH = 1024;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, init, msel, busy, coll;
  logic en_a, en_b, we_a, we_b;
  logic [9:0] ad_a, ad_b;
  logic [31:0] da, db, qa, qb;
  logic [1:0] ca, cb;

  siw_memory_bram_p dut (
    .siw_memory_bram_p_clk(clk),
    .siw_memory_bram_p_reset(rst),
    .siw_memory_bram_p_init(init),
    .siw_memory_bram_p_mem_sel(msel),
    .siw_memory_bram_p_busy(busy),
    .siw_memory_bram_p_collision(coll),
    .siw_memory_bram_p_enable_a(en_a),
    .siw_memory_bram_p_enable_b(en_b),
    .siw_memory_bram_p_write_en_a(we_a),
    .siw_memory_bram_p_write_en_b(we_b),
    .siw_memory_bram_p_address_a(ad_a),
    .siw_memory_bram_p_address_b(ad_b),
    .siw_memory_bram_p_input_data_a(da),
    .siw_memory_bram_p_input_data_b(db),
    .siw_memory_bram_p_mem_conf_a(ca),
    .siw_memory_bram_p_mem_conf_b(cb),
    .siw_memory_bram_p_output_data_a(qa),
    .siw_memory_bram_p_output_data_b(qb)
  );

  typedef struct {
    bit rst, init, msel, en_a, en_b, we_a, we_b;
    logic [9:0] ad_a, ad_b;
    logic [31:0] da, db;
    logic [1:0] ca, cb;
  } stim_t;

  typedef struct {
    int cyc;
    int kind;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int cyc = 0;
  int nvec = 0;
  int nmis = 0;

  // Reference state
  logic [31:0] mem_m [DEPTH];
  bit known [DEPTH];
  bit wea_h [NMAX];
  bit web_h [NMAX];
  int clr_edge = 0;
  bit in_clr = 0;
  int ptr = 0;
  logic [31:0] rda_m, rdb_m, outa_m, outb_m;
  bit rda_k = 0, rdb_k = 0, outa_k = 0, outb_k = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // A request reaches the memory `conf` edges after it was sampled,
  // unless an init/reset edge lies in between (or at the issuing edge).
  function automatic bit delayed(bit now, bit hist[NMAX], int n, int conf);
    if (conf == 0) return now;
    if (n - conf > clr_edge) return hist[n - conf];
    return 1'b0;
  endfunction

  task automatic drive(input stim_t s);
    int n;
    bit wra, wrb, wena, wenb, col, rak, rbk;
    logic [31:0] ra, rb;
    @(negedge clk);
    rst = s.rst; init = s.init; msel = s.msel;
    en_a = s.en_a; en_b = s.en_b; we_a = s.we_a; we_b = s.we_b;
    ad_a = s.ad_a; ad_b = s.ad_b; da = s.da; db = s.db;
    ca = s.ca; cb = s.cb;
    n = cyc + 1;
    wea_h[n] = s.we_a;
    web_h[n] = s.we_b;
    wra = delayed(s.we_a, wea_h, n, int'(s.ca));
    wrb = delayed(s.we_b, web_h, n, int'(s.cb));
    wena = wra && (s.en_a || s.msel) && !in_clr;
    wenb = wrb && s.en_b && !in_clr;
    col = wena && wenb && (s.ad_a == s.ad_b);
    ra = mem_m[s.ad_a]; rak = known[s.ad_a];
    rb = mem_m[s.ad_b]; rbk = known[s.ad_b];
    if (in_clr) begin
      mem_m[ptr] = 32'h0;
      known[ptr] = 1'b1;
    end
    if (wena) begin
      mem_m[s.ad_a] = s.da;
      known[s.ad_a] = 1'b1;
    end
    if (wenb && !col) begin
      mem_m[s.ad_b] = s.db;
      known[s.ad_b] = 1'b1;
    end
    if (s.rst) begin
      outa_m = 0; outa_k = 1; rda_m = 0; rda_k = 1;
      outb_m = 0; outb_k = 1; rdb_m = 0; rdb_k = 1;
      in_clr = 0;
    end else begin
      outa_m = rda_m; outa_k = rda_k; rda_m = ra; rda_k = rak;
      outb_m = rdb_m; outb_k = rdb_k; rdb_m = rb; rdb_k = rbk;
      if (in_clr) begin
        if (ptr == DEPTH - 1) in_clr = 0;
        else ptr++;
      end
      if (s.init) begin
        in_clr = 1;
        ptr = 0;
      end
    end
    if (s.rst || s.init) clr_edge = n;
    sb.push_back('{n, 2, {31'b0, col && !s.rst}});
    sb.push_back('{n, 3, {31'b0, in_clr}});
    if (outa_k) sb.push_back('{n, 0, outa_m});
    if (outb_k) sb.push_back('{n, 1, outb_m});
  endtask

  always @(posedge clk) begin
    exp_t it;
    logic [31:0] act;
    string nm;
    #1;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      it = sb.pop_front();
      case (it.kind)
        0: begin act = qa; nm = "out_a"; end
        1: begin act = qb; nm = "out_b"; end
        2: begin act = {31'b0, coll}; nm = "collision"; end
        default: begin act = {31'b0, busy}; nm = "busy"; end
      endcase
      nvec++;
      if (it.cyc != cyc || act !== it.val) begin
        nmis++;
        $display("FAIL %s edge=%0d got=%h expected=%h (due edge %0d)",
                 nm, cyc, act, it.val, it.cyc);
      end
    end
  end

  stim_t s;

  initial begin
    s = '{default: 0};
    s.rst = 1;
    repeat (2) drive(s);
    s.rst = 0;

    // Full sweep, reads scattered during and after it
    s.init = 1;
    drive(s);
    s.init = 0;
    for (int i = 0; i < 1030; i++) begin
      s.ad_a = 10'($urandom_range(0, DEPTH - 1));
      s.ad_b = 10'($urandom_range(0, DEPTH - 1));
      drive(s);
    end
    for (int i = 0; i < DEPTH / 2; i++) begin
      s.ad_a = 10'(2 * i);
      s.ad_b = 10'(2 * i + 1);
      drive(s);
    end

    // Delayed write, address/data held until it lands
    s.en_a = 1; s.ca = 2; s.ad_a = 10'h005; s.da = 32'hDEADBEEF;
    s.we_a = 1; drive(s);
    s.we_a = 0; repeat (2) drive(s);
    s.ad_a = 10'h006; s.ad_b = 10'h005;
    repeat (3) drive(s);

    // Host access through mem_sel, then the same write without it
    s.en_a = 0; s.msel = 1; s.ca = 0; s.ad_a = 10'h3FF;
    s.da = 32'h12345678; s.we_a = 1; drive(s);
    s.msel = 0; s.da = 32'hCAFEF00D; drive(s);
    s.we_a = 0; s.ad_b = 10'h3FF; repeat (3) drive(s);

    // Same-address collision
    s.en_a = 1; s.en_b = 1; s.ca = 0; s.cb = 0;
    s.ad_a = 10'h010; s.ad_b = 10'h010;
    s.da = 32'hAAAA0000; s.db = 32'h0000BBBB;
    s.we_a = 1; s.we_b = 1; drive(s);
    s.we_a = 0; s.we_b = 0; repeat (3) drive(s);

    // Read-first across ports
    s.ad_a = 10'h020; s.da = 32'h11; s.we_a = 1; drive(s);
    s.da = 32'h55; s.ad_b = 10'h020; drive(s);
    s.we_a = 0; repeat (3) drive(s);

    // Init chasing a delayed port-B request
    s.cb = 3; s.ad_b = 10'h040; s.db = 32'h77; s.we_b = 1; drive(s);
    s.we_b = 0; s.init = 1; drive(s);
    s.init = 0;
    for (int i = 0; i < 1030; i++) begin
      s.ad_a = 10'($urandom_range(0, 63));
      s.ad_b = 10'($urandom_range(0, 63));
      drive(s);
    end

    // Reset aborts a sweep part-way
    s = '{default: 0};
    s.en_a = 1; s.ad_a = 10'h200; s.da = 32'h5A5A5A5A; s.we_a = 1;
    drive(s);
    s.we_a = 0; s.init = 1; drive(s);
    s.init = 0; repeat (100) drive(s);
    s.rst = 1; drive(s);
    s.rst = 0;
    for (int i = 0; i < 40; i++) begin
      s.ad_a = (i % 2 == 0) ? 10'h200 : 10'(i);
      s.ad_b = 10'($urandom_range(90, 110));
      drive(s);
    end

    // Random traffic on a narrow address window
    for (int i = 0; i < 2500; i++) begin
      s.ca = 2'($urandom_range(0, 3));
      s.cb = 2'($urandom_range(0, 3));
      s.we_a = ($urandom_range(0, 9) < 4);
      s.we_b = ($urandom_range(0, 9) < 4);
      s.en_a = ($urandom_range(0, 9) < 7);
      s.en_b = ($urandom_range(0, 9) < 7);
      s.msel = ($urandom_range(0, 9) == 0);
      s.init = ($urandom_range(0, 1499) == 0);
      s.ad_a = 10'($urandom_range(0, 15));
      s.ad_b = 10'($urandom_range(0, 15));
      s.da = $urandom;
      s.db = $urandom;
      drive(s);
    end

    s = '{default: 0};
    repeat (4) drive(s);
    @(negedge clk);
    if (sb.size() != 0) begin
      nvec++;
      nmis++;
      $display("FAIL drain left=%0d expected=0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
